// File: rtl/sobel_pkg.sv
// Shared state encoding and default frame geometry for the Sobel frame controller.
package sobel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_VBLANK,
        ST_DONE
    } state_t;

    localparam int DEF_H_DISP  = 180;
    localparam int DEF_V_DISP  = 180;
    localparam int DEF_H_BLANK = 20;
    localparam int DEF_V_BLANK = 4;
    localparam int DEF_H_SYNC  = 4;
    localparam int DEF_V_SYNC  = 2;
    localparam int DEF_ADDR_W  = 15;
    localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/sobel_raster_cnt.sv
// Horizontal/vertical raster counters for one frame; held at zero while not enabled
// so every frame starts from the top-left position.
module sobel_raster_cnt
    import sobel_pkg::*;
#(
    parameter int H_TOT  = DEF_H_DISP + DEF_H_BLANK,
    parameter int V_TOT  = DEF_V_DISP + DEF_V_BLANK,
    parameter int V_DISP = DEF_V_DISP,
    parameter int HW     = $clog2(H_TOT + 1),
    parameter int VW     = $clog2(V_TOT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    output logic [HW-1:0] o_h_cnt,
    output logic [VW-1:0] o_v_cnt,
    output logic          o_line_wrap,
    output logic          o_act_end,
    output logic          o_frame_end
);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_ACT_LAST = VW'(V_DISP - 1);

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic          w_h_last;

    assign w_h_last = (r_h_cnt == H_LAST);

    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + VW'(1);
        end else begin
            r_h_cnt <= r_h_cnt + HW'(1);
        end
    end

    assign o_h_cnt     = r_h_cnt;
    assign o_v_cnt     = r_v_cnt;
    assign o_line_wrap = i_en && w_h_last;
    assign o_act_end   = o_line_wrap && (r_v_cnt == V_ACT_LAST);
    assign o_frame_end = o_line_wrap && (r_v_cnt == V_LAST);

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer: raster read addresses plus hsync/vsync/de delayed one cycle to match
// memory read latency. Define SOBEL_CTRL_CONT_MODE_EN for back-to-back frames.
module sobel_frame_ctrl
    import sobel_pkg::*;
#(
    parameter int H_DISP  = DEF_H_DISP,
    parameter int V_DISP  = DEF_V_DISP,
    parameter int H_BLANK = DEF_H_BLANK,
    parameter int V_BLANK = DEF_V_BLANK,
    parameter int H_SYNC  = DEF_H_SYNC,
    parameter int V_SYNC  = DEF_V_SYNC,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   rd_en,
    output logic [ADDR_W-1:0]      rd_addr,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   VGA_hsync,
    output logic                   VGA_vsync,
    output logic                   VGA_de
);

    localparam int H_TOT = H_DISP + H_BLANK;
    localparam int V_TOT = V_DISP + V_BLANK;
    localparam int HW    = $clog2(H_TOT + 1);
    localparam int VW    = $clog2(V_TOT + 1);

    localparam logic [HW-1:0] H_DISP_C = HW'(H_DISP);
    localparam logic [HW-1:0] HS_END   = HW'(H_DISP + H_SYNC);
    localparam logic [VW-1:0] VS_END   = VW'(V_DISP + V_SYNC);

    state_t r_state, w_state_nxt;

    logic [HW-1:0]          w_h_cnt;
    logic [VW-1:0]          w_v_cnt;
    logic                   w_run, w_line_wrap, w_act_end, w_frame_end;
    logic                   w_hsync, w_vsync, w_start_frame;
    logic [ADDR_W-1:0]      r_rd_addr;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;
    logic                   r_de, r_hsync, r_vsync;

    assign w_run = (r_state == ST_ACTIVE) || (r_state == ST_VBLANK);

    sobel_raster_cnt #(
        .H_TOT  (H_TOT),
        .V_TOT  (V_TOT),
        .V_DISP (V_DISP),
        .HW     (HW),
        .VW     (VW)
    ) u_raster (
        .clk         (clk),
        .rst         (rst),
        .i_en        (w_run),
        .o_h_cnt     (w_h_cnt),
        .o_v_cnt     (w_v_cnt),
        .o_line_wrap (w_line_wrap),
        .o_act_end   (w_act_end),
        .o_frame_end (w_frame_end)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        busy          = 1'b1;
        done          = 1'b0;
        rd_en         = 1'b0;
        w_hsync       = 1'b0;
        w_vsync       = 1'b0;
        w_start_frame = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt   = ST_ACTIVE;
                    w_start_frame = 1'b1;
                end
            end
            ST_ACTIVE: begin
                rd_en   = (w_h_cnt < H_DISP_C);
                w_hsync = (w_h_cnt >= H_DISP_C) && (w_h_cnt < HS_END);
                if (w_act_end) w_state_nxt = ST_VBLANK;
            end
            ST_VBLANK: begin
                w_hsync = (w_h_cnt >= H_DISP_C) && (w_h_cnt < HS_END);
                // Blank lines continue v_cnt from V_DISP, so the first V_SYNC of them sit below VS_END.
                w_vsync = (w_v_cnt < VS_END);
                if (w_frame_end) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
`ifdef SOBEL_CTRL_CONT_MODE_EN
                w_state_nxt   = ST_ACTIVE;
                w_start_frame = 1'b1;
`else
                w_state_nxt   = ST_IDLE;
`endif
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || w_start_frame) r_rd_addr <= '0;
        else if (rd_en)           r_rd_addr <= r_rd_addr + ADDR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)                   r_frame_cnt <= '0;
        else if (r_state == ST_DONE) r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
    end

    // One register stage so de/syncs line up with the memory's read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_de    <= 1'b0;
            r_hsync <= 1'b0;
            r_vsync <= 1'b0;
        end else begin
            r_de    <= rd_en;
            r_hsync <= w_hsync;
            r_vsync <= w_vsync;
        end
    end

    assign rd_addr   = r_rd_addr;
    assign frame_cnt = r_frame_cnt;
    assign VGA_de    = r_de;
    assign VGA_hsync = r_hsync;
    assign VGA_vsync = r_vsync;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Scoreboard bench for sobel_frame_ctrl: small-geometry DUT against a frame-position model,
// plus one default-geometry frame checked for timing and counts.
`timescale 1ns/1ps
module tb_sobel_frame_ctrl;

    localparam int HD = 4, VD = 3, HB = 2, VB = 2, HS = 1, VS = 1, AW = 8;
    localparam int HT = HD + HB, VT = VD + VB, F = HT * VT;
    localparam int DF = (180 + 20) * (180 + 4);
`ifdef SOBEL_CTRL_CONT_MODE_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, start_d;
    logic          busy, done, rd_en, hsync, vsync, de;
    logic [AW-1:0] rd_addr;
    logic [15:0]   frame_cnt;
    logic          busy_d, done_d, rd_en_d, hsync_d, vsync_d, de_d;
    logic [14:0]   rd_addr_d;
    logic [15:0]   frame_cnt_d;

    sobel_frame_ctrl #(
        .H_DISP(HD), .V_DISP(VD), .H_BLANK(HB), .V_BLANK(VB),
        .H_SYNC(HS), .V_SYNC(VS), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .frame_cnt(frame_cnt),
        .VGA_hsync(hsync), .VGA_vsync(vsync), .VGA_de(de)
    );

    sobel_frame_ctrl u_def (
        .clk(clk), .rst(rst), .start(start_d), .busy(busy_d), .done(done_d),
        .rd_en(rd_en_d), .rd_addr(rd_addr_d), .frame_cnt(frame_cnt_d),
        .VGA_hsync(hsync_d), .VGA_vsync(vsync_d), .VGA_de(de_d)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Reference model: a frame is F cycles laid out as lines of HT, then one DONE cycle.
    bit          m_valid = 0, m_busy = 0, m_after_rst = 0;
    int          m_pos = 0;
    logic [15:0] m_frames = '0;
    logic        m_prev_rd = 0, m_prev_hs = 0, m_prev_vs = 0;
    int          addr_q[$];
    logic [15:0] done_q[$];
    int          force_pend = 0, force_seen = 0;

    function automatic logic [2:0] intern(input bit b, input int pos);
        int line, col;
        logic [2:0] r;
        r = 3'b000;
        if (b && pos < F) begin
            line = pos / HT;
            col  = pos % HT;
            r[2] = (line < VD) && (col < HD);
            r[1] = (col >= HD) && (col < HD + HS);
            r[0] = (line >= VD) && (line < VD + VS);
        end
        return r;
    endfunction

    task automatic push_frame();
        for (int a = 0; a < HD * VD; a++) addr_q.push_back(a);
        done_q.push_back(m_frames);
    endtask

    initial begin
        logic [2:0] cur;
        forever begin
            @(posedge clk);
            cur = intern(m_busy, m_pos);
            if (force_pend != force_seen) begin
                m_frames   = 16'hFFFF;
                force_seen = force_pend;
            end
            if (rst) begin
                m_valid = 1; m_busy = 0; m_pos = 0; m_frames = '0; m_after_rst = 1;
                {m_prev_rd, m_prev_hs, m_prev_vs} = 3'b000;
                addr_q.delete();
                done_q.delete();
            end else begin
                {m_prev_rd, m_prev_hs, m_prev_vs} = cur;
                m_after_rst = 0;
                if (!m_busy) begin
                    if (start) begin
                        m_busy = 1; m_pos = 0; push_frame();
                    end
                end else if (m_pos == F) begin
                    m_frames = m_frames + 16'd1;
                    if (CONT) begin
                        m_pos = 0; push_frame();
                    end else begin
                        m_busy = 0;
                    end
                end else begin
                    m_pos++;
                end
            end
        end
    end

    // Monitor: per-cycle control compare, plus queued address / done-count checks.
    initial begin
        logic [2:0] e;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                e = intern(m_busy, m_pos);
                chk("busy", busy, m_busy);
                chk("done", done, m_busy && (m_pos == F));
                chk("rd_en", rd_en, e[2]);
                chk("VGA_de", de, m_prev_rd);
                chk("VGA_hsync", hsync, m_prev_hs);
                chk("VGA_vsync", vsync, m_prev_vs);
                chk("frame_cnt", frame_cnt, m_frames);
                if (m_after_rst) chk("rd_addr_after_rst", rd_addr, 0);
                if (rd_en) begin
                    chk("rd_expected", addr_q.size() > 0, 1);
                    if (addr_q.size() > 0) chk("rd_addr", rd_addr, addr_q.pop_front());
                end
                if (done) begin
                    chk("done_expected", done_q.size() > 0, 1);
                    if (done_q.size() > 0) chk("done_frame_cnt", frame_cnt, done_q.pop_front());
                end
            end
        end
    end

    initial begin
        int          n, de_cnt, first_de;
        bit          found;
        logic [14:0] last_addr;
        rst = 1; start = 0; start_d = 0;
        repeat (3) step();
        rst = 0;
        step();

        // Single frame: done at T0+F+1.
        start = 1; step(); start = 0;
        n = 1;
        while (!done && n < 4 * F) begin step(); n++; end
        chk("small_done_time", n, F + 1);
        step();
        chk("small_frame_cnt", frame_cnt, 1);

        // start held high: no queuing while busy.
        start = 1; repeat (100) step(); start = 0;
        repeat (F + 3) step();

        // Randomized start/reset traffic.
        repeat (800) begin
            start = ($urandom_range(0, 3) == 0);
            rst   = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 0; start = 0;

        // Reset mid-frame, then restart from address 0.
        rst = 1; step(); rst = 0; step();
        start = 1; step(); start = 0;
        found = 0;
        for (int i = 0; i < 4 * F && !found; i++) begin
            if (rd_en && rd_addr == 5) found = 1;
            else step();
        end
        chk("reach_addr5", found, 1);
        rst = 1; step(); rst = 0;
        chk("rst_busy", busy, 0);
        chk("rst_addr", rd_addr, 0);
        start = 1; step(); start = 0;
        chk("restart_rd_en", rd_en, 1);
        chk("restart_addr", rd_addr, 0);
        repeat (F + 3) step();

        // frame_cnt wrap from 0xFFFF.
        rst = 1; step(); rst = 0; step();
        #2 force dut.r_frame_cnt = 16'hFFFF;
        force_pend++;
        step();
        #2 release dut.r_frame_cnt;
        step();
        start = 1; step(); start = 0;
        n = 1;
        while (!done && n < 4 * F) begin step(); n++; end
        chk("wrap_done_cnt", frame_cnt, 16'hFFFF);
        step();
        chk("wrap_frame_cnt", frame_cnt, 0);

        // Default geometry, one frame.
        rst = 1; step(); rst = 0; step();
        start_d = 1; step(); start_d = 0;
        chk("def_first_rd", {rd_en_d, rd_addr_d}, {1'b1, 15'd0});
        chk("def_busy", busy_d, 1);
        n = 1; de_cnt = 0; first_de = 0; last_addr = '0;
        while (!done_d && n < DF + 10) begin
            if (rd_en_d) last_addr = rd_addr_d;
            if (de_d) begin
                de_cnt++;
                if (first_de == 0) first_de = n;
            end
            step(); n++;
        end
        chk("def_done_time", n, DF + 1);
        chk("def_de_count", de_cnt, 180 * 180);
        chk("def_first_de", first_de, 2);
        chk("def_last_addr", last_addr, 180 * 180 - 1);
        chk("def_busy_at_done", busy_d, 1);
        step();
        chk("def_frame_cnt", frame_cnt_d, 1);
        chk("def_busy_after", busy_d, CONT);

        rst = 1; step(); rst = 0; step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
